// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment bus capture monitor.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b0000011;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_D     = 7'b0100001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_F     = 7'b0001110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam int unsigned NUM_DIGITS = 4;

   typedef enum logic {EMPTY, FULL} state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational reverse lookup of an active-low segment pattern to a hex nibble.
// hit is low for any pattern outside the 16-entry table.
module seg7_decode
   import seg_pkg::*;
(
   input  logic [6:0] seg,
   output logic       hit,
   output logic [3:0] nibble
);

   always_comb begin
      hit    = 1'b1;
      nibble = '0;
      case (seg)
         SEG_0:   nibble = 4'h0;
         SEG_1:   nibble = 4'h1;
         SEG_2:   nibble = 4'h2;
         SEG_3:   nibble = 4'h3;
         SEG_4:   nibble = 4'h4;
         SEG_5:   nibble = 4'h5;
         SEG_6:   nibble = 4'h6;
         SEG_7:   nibble = 4'h7;
         SEG_8:   nibble = 4'h8;
         SEG_9:   nibble = 4'h9;
         SEG_A:   nibble = 4'hA;
         SEG_B:   nibble = 4'hB;
         SEG_C:   nibble = 4'hC;
         SEG_D:   nibble = 4'hD;
         SEG_E:   nibble = 4'hE;
         SEG_F:   nibble = 4'hF;
         default: hit    = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_scan_capture.sv
// Passive monitor of the multiplexed 7-segment bus: captures four stable digits
// into a 16-bit word on a valid/ready handshake. SEG_SCAN_CAPTURE_ERRCNT_EN builds err_cnt.
module seg_scan_capture
   import seg_pkg::*;
#(
   parameter int unsigned STABLE_CYC = 16,
   parameter int unsigned ERRCNT_W   = 8
)(
   input  logic                clk,
   input  logic                btnC_n,
   input  logic [3:0]          an,
   input  logic [6:0]          seg,
   input  logic                out_ready,
   output logic                out_valid,
   output logic [15:0]         out_value,
   output logic                err,
   output logic                overrun,
   output logic [ERRCNT_W-1:0] err_cnt
);

   localparam logic [7:0] STAB = 8'(STABLE_CYC);

   logic [3:0]                       an_q;
   logic [6:0]                       seg_q;
   logic [7:0]                       cnt, cnt_next;
   logic                             same, accept;
   logic                             hit;
   logic [3:0]                       nibble;
   logic                             blank, one_low, wr, bad, load;
   logic [NUM_DIGITS-1:0]            wr_bits, mask;
   logic [NUM_DIGITS-1:0][3:0]       slot;
   state_t                           state_q, state_next;

   seg7_decode u_dec (
      .seg    (seg_q),
      .hit    (hit),
      .nibble (nibble)
   );

   // The incoming sample is compared against the registered one, so the count
   // reaches STABLE_CYC on the edge that latches the STABLE_CYC-th identical sample.
   assign same = ({an, seg} == {an_q, seg_q});

   always_comb begin
      if (!same)
         cnt_next = 8'd1;
      else if (cnt == STAB)
         cnt_next = STAB;
      else
         cnt_next = cnt + 8'd1;
   end

   assign accept  = (cnt_next == STAB) && (cnt != STAB);
   assign blank   = (an_q == 4'b1111);
   assign one_low = $onehot(~an_q);
   assign wr      = accept && one_low && hit;
   assign bad     = accept && !blank && !(one_low && hit);
   assign wr_bits = wr ? ~an_q : '0;
   assign load    = (state_q == EMPTY) && (mask == '1);

   always_ff @(posedge clk) begin
      if (!btnC_n) begin
         an_q      <= '1;
         seg_q     <= SEG_BLANK;
         cnt       <= '0;
         mask      <= '0;
         slot      <= '0;
         out_value <= '0;
         overrun   <= 1'b0;
         err       <= 1'b0;
      end else begin
         an_q  <= an;
         seg_q <= seg;
         cnt   <= cnt_next;
         err   <= bad;
         // A digit written on the load edge starts the next frame.
         mask  <= (load ? '0 : mask) | wr_bits;
         for (int unsigned i = 0; i < NUM_DIGITS; i++)
            if (wr_bits[i])
               slot[i] <= nibble;
         if (load)
            out_value <= slot;
         if ((state_q == FULL) && (mask == '1))
            overrun <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!btnC_n)
         state_q <= EMPTY;
      else
         state_q <= state_next;
   end

   always_comb begin
      state_next = state_q;
      case (state_q)
         EMPTY:   if (mask == '1) state_next = FULL;
         FULL:    if (out_ready)  state_next = EMPTY;
         default: state_next = EMPTY;
      endcase
   end

   always_comb begin
      out_valid = (state_q == FULL);
   end

`ifdef SEG_SCAN_CAPTURE_ERRCNT_EN
   logic [ERRCNT_W-1:0] err_cnt_q;

   always_ff @(posedge clk) begin
      if (!btnC_n)
         err_cnt_q <= '0;
      else if (bad && (err_cnt_q != '1))
         err_cnt_q <= err_cnt_q + ERRCNT_W'(1);
   end

   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture with STABLE_CYC=16; err_cnt expectations
// follow SEG_SCAN_CAPTURE_ERRCNT_EN.
module tb_seg_scan_capture;
   import seg_pkg::*;

`ifdef SEG_SCAN_CAPTURE_ERRCNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        btnC_n;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        out_ready;
   logic        out_valid;
   logic [15:0] out_value;
   logic        err;
   logic        overrun;
   logic [7:0]  err_cnt;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;
   int          cyc = 0, t0 = 0;
   int          v_cnt, v_first, e_cnt, e_first;
   logic [15:0] v_val;

   always #5 clk = ~clk;

   seg_scan_capture #(.STABLE_CYC(16), .ERRCNT_W(8)) dut (
      .clk       (clk),
      .btnC_n    (btnC_n),
      .an        (an),
      .seg       (seg),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_value (out_value),
      .err       (err),
      .overrun   (overrun),
      .err_cnt   (err_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic clr();
      v_cnt = 0; v_first = 0; e_cnt = 0; e_first = 0; v_val = '0;
   endtask

   // Drive one bus pattern for n cycles, sampling outputs 1 time unit after each edge.
   task automatic step(input logic [3:0] a, input logic [6:0] s, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         an  = a;
         seg = s;
         @(posedge clk);
         #1;
         cyc++;
         if (out_valid) begin
            v_cnt++;
            if (v_first == 0) v_first = cyc;
            v_val = out_value;
         end
         if (err) begin
            e_cnt++;
            if (e_first == 0) e_first = cyc;
         end
      end
   endtask

   initial begin
      btnC_n    = 1'b0;
      out_ready = 1'b1;
      an        = 4'($urandom);
      seg       = 7'($urandom);

      // Reset with random bus activity
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         an  = 4'($urandom);
         seg = 7'($urandom);
         @(posedge clk);
      end
      #1;
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_out_value", 32'(out_value), 32'h0);
      check("rst_err",       32'(err),       32'h0);
      check("rst_overrun",   32'(overrun),   32'h0);
      check("rst_err_cnt",   32'(err_cnt),   32'h0);
      @(negedge clk);
      btnC_n = 1'b1;
      clr();
      step(4'b1111, SEG_BLANK, 20);
      check("post_rst_no_valid", 32'(v_cnt), 32'h0);

      // Full frame 4321 with consumer always ready
      clr();
      step(4'b1110, SEG_1, 20);
      step(4'b1101, SEG_2, 20);
      step(4'b1011, SEG_3, 20);
      t0 = cyc;
      step(4'b0111, SEG_4, 20);
      check("frame_valid_pulses", 32'(v_cnt),   32'd1);
      check("frame_value",        32'(v_val),   32'h4321);
      check("frame_valid_time",   32'(v_first), 32'(t0 + 17));
      check("frame_no_err",       32'(e_cnt),   32'd0);

      // Glitches: 10 and 15 cycles are both too short
      clr();
      step(4'b1110, SEG_7, 10);
      step(4'b1111, SEG_BLANK, 5);
      step(4'b1110, SEG_7, 15);
      step(4'b1111, SEG_BLANK, 5);
      step(4'b1101, SEG_5, 20);
      step(4'b1011, SEG_6, 20);
      step(4'b0111, SEG_8, 20);
      check("glitch_no_frame", 32'(v_cnt), 32'd0);
      check("glitch_no_err",   32'(e_cnt), 32'd0);
      step(4'b1110, SEG_0, 20);
      check("glitch_frame_valid", 32'(v_cnt), 32'd1);
      check("glitch_frame_value", 32'(v_val), 32'h8650);

      // Illegal pattern, then two anodes low
      clr();
      step(4'b1101, SEG_9, 20);
      step(4'b1011, SEG_E, 20);
      step(4'b0111, SEG_F, 20);
      t0 = cyc;
      step(4'b1110, 7'b1111110, 20);
      check("illegal_err_pulses", 32'(e_cnt),   32'd1);
      check("illegal_err_time",   32'(e_first), 32'(t0 + 16));
      check("illegal_err_cnt",    32'(err_cnt), CNT_EN ? 32'd1 : 32'd0);
      step(4'b1100, SEG_2, 20);
      check("two_an_err_pulses",  32'(e_cnt),   32'd2);
      check("two_an_err_cnt",     32'(err_cnt), CNT_EN ? 32'd2 : 32'd0);
      check("illegal_mask_kept",  32'(v_cnt),   32'd0);
      step(4'b1110, SEG_C, 20);
      check("illegal_frame_valid", 32'(v_cnt), 32'd1);
      check("illegal_frame_value", 32'(v_val), 32'hFE9C);

      // Mid-frame reset discards the partial frame
      clr();
      step(4'b1110, SEG_1, 20);
      step(4'b1101, SEG_2, 20);
      @(negedge clk);
      btnC_n = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_err_cnt", 32'(err_cnt),   32'h0);
      check("midrst_valid",   32'(out_valid), 32'h0);
      @(negedge clk);
      btnC_n = 1'b1;
      step(4'b1011, SEG_3, 20);
      step(4'b0111, SEG_4, 20);
      check("midrst_no_frame", 32'(v_cnt), 32'd0);
      step(4'b1110, SEG_1, 20);
      step(4'b1101, SEG_2, 20);
      check("midrst_refill_valid", 32'(v_cnt), 32'd1);
      check("midrst_refill_value", 32'(v_val), 32'h4321);

      // Backpressure and overrun
      @(negedge clk);
      out_ready = 1'b0;
      clr();
      step(4'b1110, SEG_1, 20);
      step(4'b1101, SEG_2, 20);
      step(4'b1011, SEG_3, 20);
      step(4'b0111, SEG_4, 20);
      check("bp_first_valid",   32'(out_valid), 32'h1);
      check("bp_first_value",   32'(out_value), 32'h4321);
      check("bp_no_overrun",    32'(overrun),   32'h0);
      step(4'b1110, SEG_D, 20);
      step(4'b1101, SEG_C, 20);
      step(4'b1011, SEG_B, 20);
      step(4'b0111, SEG_A, 20);
      check("bp_held_valid",    32'(out_valid), 32'h1);
      check("bp_held_value",    32'(out_value), 32'h4321);
      check("bp_overrun",       32'(overrun),   32'h1);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_handshake_drop", 32'(out_valid), 32'h0);
      @(negedge clk);
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      check("bp_second_valid",  32'(out_valid), 32'h1);
      check("bp_second_value",  32'(out_value), 32'hABCD);
      check("bp_overrun_stick", 32'(overrun),   32'h1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
